i2c_txn_arbiter: RTL

//  Shares one i2c_master engine among NREQ requesters. Each requester posts a one-byte transaction
//  (7-bit address, R/W, write byte). The arbiter grants round-robin, hands the latched command to
//  the master, watches for completion or timeout, then returns status/read data to the winner.

---
 rtl/i2c_txn_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter that shares one i2c_master among NREQ requesters.
// It latches the winning command, issues it, waits for completion or timeout, then returns status.
module i2c_txn_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*7-1:0] req_addr,
    input  logic [NREQ-1:0]   req_rw,
    input  logic [NREQ*8-1:0] req_wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [7:0]        rsp_rdata,
    output logic              rsp_nack,
    output logic              rsp_timeout,
    output logic              m_start,
    output logic [6:0]        m_addr,
    output logic              m_rw,
    output logic [7:0]        m_wdata,
    input  logic              m_done,
    input  logic              m_nack,
    input  logic [7:0]        m_rdata
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   ptr, win, pick;
    logic            pick_vld;
    logic [TO_W-1:0] cnt;
    logic            timed_out;
    logic [NREQ-1:0] win_oh;
    logic [6:0]      addr_a  [NREQ];
    logic [7:0]      wdata_a [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_a[i]  = req_addr[7*i +: 7];
        assign wdata_a[i] = req_wdata[8*i +: 8];
    end

    // Search starts just above the last winner so a held request is served within NREQ turns.
    always_comb begin : pick_search
        int idx;
        idx      = 0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!pick_vld && req[IW'(idx)]) begin
                pick     = IW'(idx);
                pick_vld = 1'b1;
            end
        end
    end

    assign timed_out = (cnt == TO_W'(TIMEOUT - 1));
    assign win_oh    = NREQ'(1) << win;
    assign gnt       = (state != IDLE) ? win_oh : '0;
    assign done      = (state == RESP) ? win_oh : '0;
    assign m_start   = (state == ISSUE);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_vld) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (m_done || timed_out) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr         <= IW'(NREQ - 1);
            win         <= '0;
            cnt         <= '0;
            m_addr      <= '0;
            m_rw        <= 1'b0;
            m_wdata     <= '0;
            rsp_rdata   <= '0;
            rsp_nack    <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: if (pick_vld) begin
                    win     <= pick;
                    m_addr  <= addr_a[pick];
                    m_rw    <= req_rw[pick];
                    m_wdata <= wdata_a[pick];
                end
                ISSUE: cnt <= '0;
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    // Completion on the timeout cycle still counts as a normal finish.
                    if (m_done) begin
                        rsp_nack    <= m_nack;
                        rsp_rdata   <= m_rdata;
                        rsp_timeout <= 1'b0;
                    end else if (timed_out) begin
                        rsp_nack    <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                    end
                end
                RESP: ptr <= win;
                default: ;
            endcase
        end
    end
endmodule
